probabilistic_search_controller: RTL and testbench

- Sequences one probabilistic-search (Metropolis-style) run over a constraint assignment.
- Obtains failed-clause counts for the current and proposed assignments from the shared clause-evaluation block.
- Drives the u/v inputs and RNG enable of the acceptance-probability block and samples its accept bit.
- Commits or discards each proposal and stops when the formula is solved or the iteration budget is exhausted.

---
 rtl/probabilistic_search_controller.sv | 154 +++++++++++++++
 tb/tb_probabilistic_search_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/probabilistic_search_controller.sv
// Metropolis-style search sequencer. It gets failed-clause counts from a shared evaluator and
// takes the accept bit from a probability block, then commits or discards each proposal.
module probabilistic_search_controller #(
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter int ASSIGNMENT_WIDTH               = 16,
  parameter int ITERATION_WIDTH                = 16,
  localparam int CW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1
) (
  input  logic                        in_clock,
  input  logic                        in_reset,
  input  logic                        in_start,
  input  logic [ITERATION_WIDTH-1:0]  in_max_iterations,
  input  logic [ASSIGNMENT_WIDTH-1:0] in_initial_assignment,
  input  logic                        in_proposal_valid,
  input  logic [ASSIGNMENT_WIDTH-1:0] in_proposal,
  output logic                        out_proposal_ready,
  output logic                        out_count_request,
  output logic [ASSIGNMENT_WIDTH-1:0] out_count_assignment,
  input  logic                        in_count_valid,
  input  logic [CW-1:0]               in_failed_count,
  output logic [CW-1:0]               out_u,
  output logic [CW-1:0]               out_v,
  output logic                        out_rng_enable,
  input  logic                        in_accept,
  output logic [ASSIGNMENT_WIDTH-1:0] out_assignment,
  output logic [ITERATION_WIDTH-1:0]  out_iteration,
  output logic                        out_busy,
  output logic                        out_done,
  output logic                        out_solved
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_COUNT, S_WAIT_PROPOSAL, S_COUNT_NEW, S_DECIDE, S_FINISH
  } state_t;

  state_t                      state_q, state_d;
  logic [ASSIGNMENT_WIDTH-1:0] assignment_q, assignment_d;
  logic [ASSIGNMENT_WIDTH-1:0] proposal_q, proposal_d;
  logic [ITERATION_WIDTH-1:0]  budget_q, budget_d;
  logic [ITERATION_WIDTH-1:0]  iteration_q, iteration_d;
  logic [CW-1:0]               u_q, u_d;
  logic [CW-1:0]               v_q, v_d;
  logic                        solved_q, solved_d;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q      <= S_IDLE;
      assignment_q <= '0;
      proposal_q   <= '0;
      budget_q     <= '0;
      iteration_q  <= '0;
      u_q          <= '0;
      v_q          <= '0;
      solved_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      assignment_q <= assignment_d;
      proposal_q   <= proposal_d;
      budget_q     <= budget_d;
      iteration_q  <= iteration_d;
      u_q          <= u_d;
      v_q          <= v_d;
      solved_q     <= solved_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    assignment_d         = assignment_q;
    proposal_d           = proposal_q;
    budget_d             = budget_q;
    iteration_d          = iteration_q;
    u_d                  = u_q;
    v_d                  = v_q;
    solved_d             = solved_q;
    out_proposal_ready   = 1'b0;
    out_count_request    = 1'b0;
    out_count_assignment = '0;
    out_rng_enable       = 1'b0;
    out_done             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          assignment_d = in_initial_assignment;
          budget_d     = in_max_iterations;
          iteration_d  = '0;
          solved_d     = 1'b0;
          u_d          = '0;
          v_d          = '0;
          state_d      = S_INIT_COUNT;
        end
      end
      S_INIT_COUNT: begin
        out_count_request    = 1'b1;
        out_count_assignment = assignment_q;
        if (in_count_valid) begin
          u_d = in_failed_count;
          if (in_failed_count == '0) begin
            solved_d = 1'b1;
            state_d  = S_FINISH;
          end else begin
            state_d = S_WAIT_PROPOSAL;
          end
        end
      end
      S_WAIT_PROPOSAL: begin
        out_proposal_ready = 1'b1;
        if (in_proposal_valid) begin
          proposal_d = in_proposal;
          state_d    = S_COUNT_NEW;
        end
      end
      S_COUNT_NEW: begin
        out_count_request    = 1'b1;
        out_count_assignment = proposal_q;
        if (in_count_valid) begin
          v_d     = in_failed_count;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        // The probability block sees the registered u/v this cycle, so in_accept is already valid.
        out_rng_enable = 1'b1;
        iteration_d    = iteration_q + 1'b1;
        if (in_accept) begin
          assignment_d = proposal_q;
          u_d          = v_q;
        end
        if (in_accept && (v_q == '0)) begin
          solved_d = 1'b1;
          state_d  = S_FINISH;
        end else if ((budget_q != '0) && (iteration_d == budget_q)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT_PROPOSAL;
        end
      end
      S_FINISH: begin
        out_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_u          = u_q;
  assign out_v          = v_q;
  assign out_assignment = assignment_q;
  assign out_iteration  = iteration_q;
  assign out_solved     = solved_q;
  assign out_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_probabilistic_search_controller.sv
// Directed bench for probabilistic_search_controller. Inputs are driven and outputs are checked
// on the falling clock edge, and the evaluator and probability block are played by hand.
module tb_probabilistic_search_controller;

  logic        in_clock = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_start = 1'b0;
  logic [15:0] in_max_iterations = '0;
  logic [15:0] in_initial_assignment = '0;
  logic        in_proposal_valid = 1'b0;
  logic [15:0] in_proposal = '0;
  logic        out_proposal_ready;
  logic        out_count_request;
  logic [15:0] out_count_assignment;
  logic        in_count_valid = 1'b0;
  logic [3:0]  in_failed_count = '0;
  logic [3:0]  out_u;
  logic [3:0]  out_v;
  logic        out_rng_enable;
  logic        in_accept = 1'b0;
  logic [15:0] out_assignment;
  logic [15:0] out_iteration;
  logic        out_busy;
  logic        out_done;
  logic        out_solved;

  int n_checks = 0;
  int n_fail   = 0;
  int handshakes = 0;

  probabilistic_search_controller #(
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX(3),
    .ASSIGNMENT_WIDTH(16),
    .ITERATION_WIDTH(16)
  ) dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start),
    .in_max_iterations(in_max_iterations), .in_initial_assignment(in_initial_assignment),
    .in_proposal_valid(in_proposal_valid), .in_proposal(in_proposal),
    .out_proposal_ready(out_proposal_ready), .out_count_request(out_count_request),
    .out_count_assignment(out_count_assignment), .in_count_valid(in_count_valid),
    .in_failed_count(in_failed_count), .out_u(out_u), .out_v(out_v),
    .out_rng_enable(out_rng_enable), .in_accept(in_accept), .out_assignment(out_assignment),
    .out_iteration(out_iteration), .out_busy(out_busy), .out_done(out_done),
    .out_solved(out_solved)
  );

  always #5 in_clock = ~in_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge in_clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] init, input logic [15:0] budget);
    in_initial_assignment = init;
    in_max_iterations     = budget;
    in_start              = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic give_count(input string tag, input logic [3:0] c);
    chk({tag, " request"}, {31'd0, out_count_request}, 32'd1);
    in_failed_count = c;
    in_count_valid  = 1'b1;
    tick();
    in_count_valid = 1'b0;
  endtask

  task automatic give_prop(input string tag, input logic [15:0] p);
    chk({tag, " ready"}, {31'd0, out_proposal_ready}, 32'd1);
    if (out_proposal_ready) handshakes++;
    in_proposal       = p;
    in_proposal_valid = 1'b1;
    tick();
    in_proposal_valid = 1'b0;
  endtask

  task automatic decide(input string tag, input logic a);
    chk({tag, " rng_enable"}, {31'd0, out_rng_enable}, 32'd1);
    in_accept = a;
    tick();
    in_accept = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, {31'd0, out_busy}, 32'd0);
    chk({tag, " done"}, {31'd0, out_done}, 32'd0);
    chk({tag, " solved"}, {31'd0, out_solved}, 32'd0);
    chk({tag, " request"}, {31'd0, out_count_request}, 32'd0);
    chk({tag, " ready"}, {31'd0, out_proposal_ready}, 32'd0);
    chk({tag, " rng"}, {31'd0, out_rng_enable}, 32'd0);
    chk({tag, " assignment"}, {16'd0, out_assignment}, 32'd0);
    chk({tag, " count_assignment"}, {16'd0, out_count_assignment}, 32'd0);
    chk({tag, " iteration"}, {16'd0, out_iteration}, 32'd0);
    chk({tag, " u"}, {28'd0, out_u}, 32'd0);
    chk({tag, " v"}, {28'd0, out_v}, 32'd0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    in_reset = 1'b0;

    // Run A: the initial assignment already satisfies every clause
    start_run(16'h00A5, 16'd0);
    chk("A count_assignment", {16'd0, out_count_assignment}, 32'h00A5);
    chk("A busy", {31'd0, out_busy}, 32'd1);
    give_count("A init", 4'd0);
    chk("A done", {31'd0, out_done}, 32'd1);
    chk("A solved", {31'd0, out_solved}, 32'd1);
    chk("A ready", {31'd0, out_proposal_ready}, 32'd0);
    chk("A iteration", {16'd0, out_iteration}, 32'd0);
    chk("A assignment", {16'd0, out_assignment}, 32'h00A5);
    tick();
    chk("A done pulse", {31'd0, out_done}, 32'd0);
    chk("A idle busy", {31'd0, out_busy}, 32'd0);
    chk("A solved held", {31'd0, out_solved}, 32'd1);

    // Run B: accept an improving proposal, then a proposal that solves the formula
    start_run(16'h0F0F, 16'd0);
    chk("B solved cleared", {31'd0, out_solved}, 32'd0);
    chk("B count_assignment", {16'd0, out_count_assignment}, 32'h0F0F);
    give_count("B init", 4'd3);
    chk("B u", {28'd0, out_u}, 32'd3);
    in_initial_assignment = 16'hDEAD;
    in_start        = 1'b1;
    in_count_valid  = 1'b1;
    in_failed_count = 4'd0;
    tick();
    in_start       = 1'b0;
    in_count_valid = 1'b0;
    chk("B ignore start ready", {31'd0, out_proposal_ready}, 32'd1);
    chk("B ignore start assignment", {16'd0, out_assignment}, 32'h0F0F);
    chk("B ignore valid u", {28'd0, out_u}, 32'd3);
    give_prop("B p1", 16'h1234);
    chk("B p1 count_assignment", {16'd0, out_count_assignment}, 32'h1234);
    chk("B p1 ready low", {31'd0, out_proposal_ready}, 32'd0);
    give_count("B p1", 4'd1);
    chk("B p1 v", {28'd0, out_v}, 32'd1);
    chk("B p1 u before", {28'd0, out_u}, 32'd3);
    decide("B p1", 1'b1);
    chk("B p1 assignment", {16'd0, out_assignment}, 32'h1234);
    chk("B p1 u", {28'd0, out_u}, 32'd1);
    chk("B p1 iteration", {16'd0, out_iteration}, 32'd1);
    chk("B p1 rng low", {31'd0, out_rng_enable}, 32'd0);
    chk("B p1 back to wait", {31'd0, out_proposal_ready}, 32'd1);
    chk("B p1 no done", {31'd0, out_done}, 32'd0);
    give_prop("B p2", 16'h2222);
    give_count("B p2", 4'd0);
    decide("B p2", 1'b1);
    chk("B p2 done", {31'd0, out_done}, 32'd1);
    chk("B p2 solved", {31'd0, out_solved}, 32'd1);
    chk("B p2 iteration", {16'd0, out_iteration}, 32'd2);
    chk("B p2 assignment", {16'd0, out_assignment}, 32'h2222);
    tick();
    chk("B idle busy", {31'd0, out_busy}, 32'd0);

    // Run C: budget of 3 with every proposal rejected
    handshakes = 0;
    start_run(16'h0BEE, 16'd3);
    give_count("C init", 4'd2);
    give_prop("C p1", 16'h7777);
    give_count("C p1", 4'd5);
    decide("C p1", 1'b0);
    chk("C p1 assignment", {16'd0, out_assignment}, 32'h0BEE);
    chk("C p1 u", {28'd0, out_u}, 32'd2);
    chk("C p1 iteration", {16'd0, out_iteration}, 32'd1);
    chk("C p1 no done", {31'd0, out_done}, 32'd0);
    give_prop("C p2", 16'h1111);
    give_count("C p2", 4'd6);
    decide("C p2", 1'b0);
    chk("C p2 no done", {31'd0, out_done}, 32'd0);
    give_prop("C p3", 16'h3333);
    give_count("C p3", 4'd6);
    decide("C p3", 1'b0);
    chk("C done", {31'd0, out_done}, 32'd1);
    chk("C solved", {31'd0, out_solved}, 32'd0);
    chk("C iteration", {16'd0, out_iteration}, 32'd3);
    chk("C handshakes", handshakes, 32'd3);
    tick();
    chk("C idle ready", {31'd0, out_proposal_ready}, 32'd0);
    chk("C iteration held", {16'd0, out_iteration}, 32'd3);

    // Run D: a solving accept on the last budgeted proposal still counts as solved
    start_run(16'h0001, 16'd2);
    give_count("D init", 4'd4);
    give_prop("D p1", 16'h0003);
    give_count("D p1", 4'd2);
    decide("D p1", 1'b0);
    give_prop("D p2", 16'h0007);
    give_count("D p2", 4'd0);
    decide("D p2", 1'b1);
    chk("D done", {31'd0, out_done}, 32'd1);
    chk("D solved", {31'd0, out_solved}, 32'd1);
    chk("D iteration", {16'd0, out_iteration}, 32'd2);
    chk("D assignment", {16'd0, out_assignment}, 32'h0007);
    tick();

    // Run E: asynchronous reset while counting a proposal, then a fresh run
    start_run(16'h00FF, 16'd0);
    give_count("E init", 4'd3);
    give_prop("E p1", 16'h0F00);
    chk("E count_new request", {31'd0, out_count_request}, 32'd1);
    #2 in_reset = 1'b1;
    #1;
    chk_all_zero("E async reset");
    tick();
    tick();
    chk("E reset no done", {31'd0, out_done}, 32'd0);
    in_reset = 1'b0;
    start_run(16'h0ABC, 16'd1);
    chk("E restart assignment", {16'd0, out_assignment}, 32'h0ABC);
    give_count("E restart init", 4'd1);
    give_prop("E restart p1", 16'h0DEF);
    give_count("E restart p1", 4'd1);
    decide("E restart p1", 1'b1);
    chk("E done", {31'd0, out_done}, 32'd1);
    chk("E solved", {31'd0, out_solved}, 32'd0);
    chk("E assignment", {16'd0, out_assignment}, 32'h0DEF);
    chk("E iteration", {16'd0, out_iteration}, 32'd1);
    chk("E u", {28'd0, out_u}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
